user_core_bus_arb: RTL and testbench

- Shares one native memory port (valid/ready, 32-bit) between the user core's instruction-fetch port and data port.
- Each core-side port uses a req/ack handshake.
- Sits inside user_core_design, between the core's IDREQ/IDACK and DDREQ/DDACK channels and the SoC-side memory interface.
- Provides round-robin arbitration, single outstanding transaction, registered outputs, and a per-transaction timeout that reports a bus error.

---
 rtl/user_core_bus_arb_if.sv | 45 ++++
 rtl/user_core_bus_arb.sv | 156 +++++++++++++++
 tb/tb_user_core_bus_arb.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_core_bus_arb_if.sv
// Core-side req/ack channels and SoC-side valid/ready memory port shared by the arbiter.
interface user_core_bus_arb_if;
  logic        inst_req_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_rdata_o;
  logic        inst_ack_o;

  logic        data_req_i;
  logic        data_rd_i;
  logic        data_wr_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [3:0]  data_wstrb_i;
  logic [31:0] data_rdata_o;
  logic        data_ack_o;

  logic        berr_o;

  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;

  // Core and memory side, as seen from outside the arbiter
  modport master (
    output inst_req_i, inst_addr_i,
    input  inst_rdata_o, inst_ack_o,
    output data_req_i, data_rd_i, data_wr_i, data_addr_i, data_wdata_i, data_wstrb_i,
    input  data_rdata_o, data_ack_o, berr_o,
    input  mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    output mem_ready_i, mem_rdata_i
  );

  // Arbiter view
  modport slave (
    input  inst_req_i, inst_addr_i,
    output inst_rdata_o, inst_ack_o,
    input  data_req_i, data_rd_i, data_wr_i, data_addr_i, data_wdata_i, data_wstrb_i,
    output data_rdata_o, data_ack_o, berr_o,
    output mem_valid_o, mem_addr_o, mem_wdata_o, mem_wstrb_o,
    input  mem_ready_i, mem_rdata_i
  );
endinterface

// File: rtl/user_core_bus_arb.sv
// Round-robin arbiter sharing one valid/ready memory port between the core's fetch and data
// ports; single outstanding transaction, registered outputs, timeout reported as bus error.
module user_core_bus_arb #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          FIRST_DATA  = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  user_core_bus_arb_if.slave bus
);

  localparam int unsigned CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam bit          TO_EN    = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;  // 1 = data port won last
  logic               mem_valid_q, mem_valid_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic [31:0]        inst_rdata_q, inst_rdata_d;
  logic [31:0]        data_rdata_q, data_rdata_d;
  logic               inst_ack_q, inst_ack_d;
  logic               data_ack_q, data_ack_d;
  logic               berr_q, berr_d;

  logic               grant_inst_c;
  logic               grant_data_c;
  logic               timeout_hit_c;
  logic               done_c;
  logic               unused_rd_c;

  // Data wins when alone, or when both request and the instruction port was served last
  assign grant_data_c  = bus.data_req_i && (!bus.inst_req_i || !last_grant_q);
  assign grant_inst_c  = bus.inst_req_i && !grant_data_c;
  assign timeout_hit_c = TO_EN && !bus.mem_ready_i && (cnt_q == CNT_W'(TO_LIMIT));
  assign done_c        = bus.mem_ready_i || timeout_hit_c;
  // A data access without the write qualifier is a read, so the read qualifier carries no information
  assign unused_rd_c   = bus.data_rd_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_data_c)      state_d = BUSY_D;
        else if (grant_inst_c) state_d = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (done_c) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = mem_wstrb_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_ack_d   = 1'b0;
    data_ack_d   = 1'b0;
    berr_d       = 1'b0;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (grant_data_c) begin
          mem_valid_d  = 1'b1;
          mem_addr_d   = bus.data_addr_i;
          mem_wdata_d  = bus.data_wdata_i;
          mem_wstrb_d  = bus.data_wr_i ? bus.data_wstrb_i : 4'b0000;
          last_grant_d = 1'b1;
        end else if (grant_inst_c) begin
          mem_valid_d  = 1'b1;
          mem_addr_d   = bus.inst_addr_i;
          mem_wdata_d  = '0;
          mem_wstrb_d  = 4'b0000;
          last_grant_d = 1'b0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done_c) begin
          mem_valid_d = 1'b0;
          cnt_d       = '0;
          berr_d      = !bus.mem_ready_i;
          if (state_q == BUSY_D) begin
            data_ack_d   = 1'b1;
            data_rdata_d = bus.mem_ready_i ? bus.mem_rdata_i : 32'h0;
          end else begin
            inst_ack_d   = 1'b1;
            inst_rdata_d = bus.mem_ready_i ? bus.mem_rdata_i : 32'h0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and arbitration history
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      last_grant_q <= ~FIRST_DATA;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_ack_q   <= 1'b0;
      data_ack_q   <= 1'b0;
      berr_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_ack_q   <= inst_ack_d;
      data_ack_q   <= data_ack_d;
      berr_q       <= berr_d;
    end
  end

  assign bus.mem_valid_o  = mem_valid_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.mem_wstrb_o  = mem_wstrb_q;
  assign bus.inst_rdata_o = inst_rdata_q;
  assign bus.data_rdata_o = data_rdata_q;
  assign bus.inst_ack_o   = inst_ack_q;
  assign bus.data_ack_o   = data_ack_q;
  assign bus.berr_o       = berr_q;

endmodule

// File: tb/tb_user_core_bus_arb.sv
// Directed scoreboard bench for user_core_bus_arb: expected transactions are queued at issue,
// checked on the memory side at grant and on the core side at ack.
module tb_user_core_bus_arb;

  localparam int unsigned TO_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  user_core_bus_arb_if bus();

  user_core_bus_arb #(.TIMEOUT_CYC(TO_CYC), .FIRST_DATA(1'b0)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit          port;   // 1 = data
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    bit          berr;
    int          vcyc;   // expected cycles with mem_valid_o high, 0 = don't care
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_fail   = 0;
  bit          mem_hang = 1'b0;
  int          mem_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] inst_rd_exp = 32'h0;
  logic [31:0] data_rd_exp = 32'h0;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'h0000_0013 : (a ^ 32'hC3C3_0F0F);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Memory: answers after mem_delay waiting cycles unless hung
  always @(negedge clk) begin
    if (bus.mem_valid_o && !bus.mem_ready_i && !mem_hang && wait_cnt >= mem_delay) begin
      bus.mem_ready_i = 1'b1;
      bus.mem_rdata_i = mem_f(bus.mem_addr_o);
      wait_cnt        = 0;
    end else begin
      bus.mem_ready_i = 1'b0;
      bus.mem_rdata_i = 32'hDEAD_DEAD;
      if (bus.mem_valid_o) wait_cnt++;
      else                 wait_cnt = 0;
    end
  end

  // Monitor: grant fields against the queue head, completion against the popped entry
  bit   prev_valid = 1'b0;
  int   vcyc = 0;
  exp_t cur;
  always @(negedge clk) begin
    exp_t e;
    if (bus.mem_valid_o) begin
      if (!prev_valid) begin
        vcyc = 1;
        check("grant_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          cur = sb[0];
          check("grant_addr", bus.mem_addr_o, cur.addr);
          check("grant_wstrb", 32'(bus.mem_wstrb_o), 32'(cur.wstrb));
          if (cur.port) check("grant_wdata", bus.mem_wdata_o, cur.wdata);
        end
      end else begin
        vcyc++;
        check("hold_addr", bus.mem_addr_o, cur.addr);
        check("hold_wstrb", 32'(bus.mem_wstrb_o), 32'(cur.wstrb));
      end
    end
    prev_valid = bus.mem_valid_o;

    if (bus.berr_o) check("berr_with_ack", 32'(bus.inst_ack_o | bus.data_ack_o), 32'd1);

    if (bus.inst_ack_o || bus.data_ack_o) begin
      check("ack_has_entry", 32'(sb.size() > 0), 32'd1);
      check("ack_exclusive", 32'(bus.inst_ack_o & bus.data_ack_o), 32'd0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ack_port", 32'(bus.data_ack_o), 32'(e.port));
        check("berr", 32'(bus.berr_o), 32'(e.berr));
        if (e.vcyc > 0) check("valid_cycles", 32'(vcyc), 32'(e.vcyc));
        if (e.port) begin
          check("data_rdata", bus.data_rdata_o, e.rdata);
          check("inst_rdata_hold", bus.inst_rdata_o, inst_rd_exp);
          data_rd_exp = e.rdata;
        end else begin
          check("inst_rdata", bus.inst_rdata_o, e.rdata);
          check("data_rdata_hold", bus.data_rdata_o, data_rd_exp);
          inst_rd_exp = e.rdata;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic issue_inst(input logic [31:0] a, input int vc);
    exp_t e;
    e.port = 1'b0; e.addr = a; e.wdata = 32'h0; e.wstrb = 4'b0000;
    e.rdata = mem_f(a); e.berr = 1'b0; e.vcyc = vc;
    sb.push_back(e);
    bus.inst_addr_i = a;
    bus.inst_req_i  = 1'b1;
  endtask

  task automatic issue_data(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                            input bit wr, input bit rd, input logic [3:0] exp_st,
                            input bit err, input int vc);
    exp_t e;
    e.port = 1'b1; e.addr = a; e.wdata = wd; e.wstrb = exp_st;
    e.rdata = err ? 32'h0 : mem_f(a); e.berr = err; e.vcyc = vc;
    sb.push_back(e);
    bus.data_addr_i  = a;
    bus.data_wdata_i = wd;
    bus.data_wstrb_i = st;
    bus.data_wr_i    = wr;
    bus.data_rd_i    = rd;
    bus.data_req_i   = 1'b1;
  endtask

  task automatic wait_ack(input bit port, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      seen = port ? bus.data_ack_o : bus.inst_ack_o;
    end
    check(port ? "data_ack_seen" : "inst_ack_seen", 32'(seen), 32'd1);
    if (port) bus.data_req_i = 1'b0;
    else      bus.inst_req_i = 1'b0;
  endtask

  initial begin
    int acks;
    int i_n;
    int d_n;
    bus.inst_req_i = 1'b0; bus.inst_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_rd_i = 1'b0; bus.data_wr_i = 1'b0;
    bus.data_addr_i = '0; bus.data_wdata_i = '0; bus.data_wstrb_i = '0;
    bus.mem_ready_i = 1'b0; bus.mem_rdata_i = '0;

    // Reset state
    idle(3);
    check("rst_mem_valid", 32'(bus.mem_valid_o), 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb_o), 32'd0);
    check("rst_acks", 32'({bus.inst_ack_o, bus.data_ack_o, bus.berr_o}), 32'd0);
    check("rst_inst_rdata", bus.inst_rdata_o, 32'h0);
    check("rst_data_rdata", bus.data_rdata_o, 32'h0);
    rst = 1'b0;
    idle(2);

    // Contention right after reset: expect I, D, I, D
    mem_delay = 1;
    issue_inst(32'h0000_2000, 2);
    issue_data(32'h2000_0000, 32'h1111_1111, 4'hF, 1'b0, 1'b1, 4'h0, 1'b0, 2);
    acks = 0; i_n = 1; d_n = 1;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (bus.inst_ack_o) begin
        acks++;
        if (i_n < 2) begin issue_inst(32'h0000_2004, 2); i_n++; end
        else bus.inst_req_i = 1'b0;
      end
      if (bus.data_ack_o) begin
        acks++;
        if (d_n < 2) begin
          issue_data(32'h2000_0008, 32'h2222_2222, 4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 2);
          d_n++;
        end else bus.data_req_i = 1'b0;
      end
    end
    check("contention_acks", 32'(acks), 32'd4);
    bus.inst_req_i = 1'b0; bus.data_req_i = 1'b0;
    idle(2);

    // Single fetch, one-cycle grant latency
    mem_delay = 2;
    issue_inst(32'h0000_0100, 3);
    @(negedge clk);
    check("fetch_latency", 32'(bus.mem_valid_o), 32'd1);
    wait_ack(1'b0, 20);
    idle(2);

    // Data write, immediate ready
    mem_delay = 0;
    issue_data(32'h1000_0004, 32'hA5A5_5A5A, 4'b0011, 1'b1, 1'b0, 4'b0011, 1'b0, 1);
    wait_ack(1'b1, 20);
    idle(2);

    // Data access with neither qualifier is a read; write with zero strobes is issued as a read
    issue_data(32'h1000_0010, 32'h0BAD_F00D, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 1);
    wait_ack(1'b1, 20);
    idle(1);
    issue_data(32'h1000_0014, 32'h1234_5678, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1);
    wait_ack(1'b1, 20);
    idle(2);

    // Timeout: memory never answers
    mem_hang = 1'b1;
    issue_data(32'h3000_0000, 32'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b1, int'(TO_CYC));
    wait_ack(1'b1, 40);
    mem_hang = 1'b0;
    idle(2);
    issue_data(32'h3000_0004, 32'h0, 4'h0, 1'b0, 1'b1, 4'h0, 1'b0, 1);
    wait_ack(1'b1, 20);
    idle(2);

    // Ready in the same cycle as the timeout limit completes normally
    mem_delay = int'(TO_CYC) - 1;
    issue_inst(32'h0000_4000, int'(TO_CYC));
    wait_ack(1'b0, 40);
    mem_delay = 0;
    idle(2);

    // Reset while BUSY_D: no ack, then a fetch completes normally
    mem_hang = 1'b1;
    issue_data(32'h5000_0000, 32'hCAFE_0001, 4'hF, 1'b1, 1'b0, 4'hF, 1'b0, 0);
    idle(4);
    check("busy_before_rst", 32'(bus.mem_valid_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_drops_valid", 32'(bus.mem_valid_o), 32'd0);
    check("rst_no_data_ack", 32'(bus.data_ack_o), 32'd0);
    sb.delete();
    bus.data_req_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_hang = 1'b0;
    inst_rd_exp = 32'h0;
    data_rd_exp = 32'h0;
    idle(3);
    issue_inst(32'h0000_0100, 1);
    wait_ack(1'b0, 20);
    idle(3);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
